// File: rtl/keypad_event_if.sv
// Event handshake bundle between the keypad controller and the code consumer.
interface keypad_event_if #(
  parameter int unsigned CODE_W = 4
);
  logic [CODE_W-1:0] out_key;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_key, output out_valid, input out_ready);
  modport slave  (input out_key, input out_valid, output out_ready);
endinterface

// File: rtl/keypad_event_controller.sv
// Synchronises, debounces and arbitrates raw key lines into one coded event per press.
// Optional auto-repeat while a key stays held is enabled by defining KEY_REPEAT_EN.
module keypad_event_controller #(
  parameter int unsigned NUM_KEYS        = 9,
  parameter int unsigned CODE_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] in_key,
  output logic                busy,
  keypad_event_if.master      evt
);

  localparam int unsigned SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      NUM_KEYS >= (2 ** CODE_W)) begin : g_param_check
    $error("keypad_event_controller: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_EMIT     = 2'd2,
    S_HOLD     = 2'd3
  } state_e;

  state_e              state_q;
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync_key_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CODE_W-1:0]   key_q;
  logic                valid_q;
  logic                busy_q;
  logic                any_key_c;
  logic [SEL_W-1:0]    low_idx_c;
  logic                key_hit_c;
  logic [CODE_W-1:0]   sel_code_c;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic             rpt_is_q;
  logic [RPT_W-1:0] rpt_lim_c;

  // First repeat waits the long delay; later ones use the shorter rate.
  assign rpt_lim_c = rpt_is_q ? RPT_W'(REPEAT_RATE - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

  // Two-flop synchroniser on every raw line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync_key_q <= '0;
    end else begin
      sync1_q    <= in_key;
      sync_key_q <= sync1_q;
    end
  end

  // Lowest set index wins arbitration.
  always_comb begin
    any_key_c = 1'b0;
    low_idx_c = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync_key_q[i]) begin
        any_key_c = 1'b1;
        low_idx_c = SEL_W'(i);
      end
    end
  end

  assign key_hit_c  = sync_key_q[sel_q];
  assign sel_code_c = CODE_W'(sel_q) + CODE_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt_q <= '0;
      rpt_is_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_key_c) begin
            sel_q   <= low_idx_c;
            cnt_q   <= '0;
            state_q <= S_DEBOUNCE;
            busy_q  <= 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!key_hit_c) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_q  <= S_EMIT;
            key_q    <= sel_code_c;
            valid_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_is_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EMIT: begin
          // Event is held regardless of key activity until the consumer takes it.
          if (evt.out_ready) begin
            valid_q   <= 1'b0;
            key_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_HOLD;
`ifdef KEY_REPEAT_EN
            rpt_cnt_q <= '0;
`endif
          end
        end
        S_HOLD: begin
          if (key_hit_c) begin
            cnt_q <= '0;
`ifdef KEY_REPEAT_EN
            if (rpt_cnt_q == rpt_lim_c) begin
              state_q   <= S_EMIT;
              key_q     <= sel_code_c;
              valid_q   <= 1'b1;
              rpt_is_q  <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
`endif
          end else begin
`ifdef KEY_REPEAT_EN
            rpt_cnt_q <= '0;
`endif
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign evt.out_key   = key_q;
  assign evt.out_valid = valid_q;
  assign busy          = busy_q;

endmodule
